// File: rtl/decoder_pipe_if.sv
// Handshake bundle for decoder_pipe: a code stream in (din) and a one-hot stream out (dout).
// slave  : the decoder's view (consumes din, produces dout)
// master : the environment's view (produces din, consumes dout)
interface decoder_pipe_if #(
   parameter int N = 3
);
   logic [N-1:0]    din;
   logic            din_valid;
   logic            din_ready;
   logic [2**N-1:0] dout;
   logic            dout_valid;
   logic            dout_ready;
   logic            busy;

   modport slave (
      input  din, din_valid, dout_ready,
      output din_ready, dout, dout_valid, busy
   );

   modport master (
      output din, din_valid, dout_ready,
      input  din_ready, dout, dout_valid, busy
   );
endinterface

// File: rtl/decoder_pipe.sv
// decoder_pipe: binary-to-one-hot decoder behind a 2-entry valid/ready FIFO.
// Decode happens at capture, so the FIFO stores one-hot words.
// Optional macro DECODER_PIPE_HITCNT_EN adds per-bit saturating output hit
// counters readable through cnt_sel/cnt_out, cleared by cnt_clr.
module decoder_pipe #(
   parameter int N = 3
) (
   input  logic             clk,
   input  logic             rst,
   decoder_pipe_if.slave    bus
`ifdef DECODER_PIPE_HITCNT_EN
   ,
   input  logic [N-1:0]     cnt_sel,
   input  logic             cnt_clr,
   output logic [7:0]       cnt_out
`endif
);
   localparam int W = 2**N;

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   state_t         state, state_nxt;
   logic           rdy;
   logic           in_xfer, out_xfer;
   logic [W-1:0]   dec;
   logic [W-1:0]   head_p0;   // oldest entry, drives dout
   logic [W-1:0]   tail_p1;   // second entry, valid only in TWO

   assign dec      = W'(1) << bus.din;
   assign in_xfer  = bus.din_valid & rdy;
   assign out_xfer = (state != EMPTY) & bus.dout_ready;

   assign bus.din_ready  = rdy;
   assign bus.dout_valid = (state != EMPTY);
   assign bus.busy       = (state != EMPTY);
   assign bus.dout       = (state != EMPTY) ? head_p0 : '0;

   // Next-state selection from occupancy and the two transfer strobes
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (in_xfer) state_nxt = ONE;
         ONE: begin
            if (in_xfer && !out_xfer)      state_nxt = TWO;
            else if (!in_xfer && out_xfer) state_nxt = EMPTY;
         end
         TWO:     if (out_xfer) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
   end

   // Occupancy state and registered ready (ready follows next occupancy, never dout_ready directly)
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         rdy   <= 1'b1;
      end else begin
         state <= state_nxt;
         rdy   <= (state_nxt != TWO);
      end
   end

   // Entry storage; unreset because dout is masked whenever the FIFO is empty
   always_ff @(posedge clk) begin
      case (state)
         EMPTY: if (in_xfer) head_p0 <= dec;
         ONE: begin
            if (in_xfer && out_xfer) head_p0 <= dec;
            else if (in_xfer)        tail_p1 <= dec;
         end
         TWO:     if (out_xfer) head_p0 <= tail_p1;
         default: ;
      endcase
   end

`ifdef DECODER_PIPE_HITCNT_EN
   logic [7:0] cnt [0:W-1];

   // Per-bit hit counters: saturate at 255, clear beats increment
   always_ff @(posedge clk) begin
      for (int i = 0; i < W; i++) begin
         if (rst || cnt_clr)
            cnt[i] <= 8'd0;
         else if (out_xfer && head_p0[i] && cnt[i] != 8'hFF)
            cnt[i] <= cnt[i] + 8'd1;
      end
   end

   // Registered counter readback
   always_ff @(posedge clk) begin
      if (rst) cnt_out <= 8'd0;
      else     cnt_out <= cnt[cnt_sel];
   end
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// Bench for decoder_pipe: cycle vector table for the basic and back-pressure
// sequences, a queue scoreboard watching every output transfer, and
// hand-written streaming, reset and random sequences.
module tb_decoder_pipe;
   localparam int N = 3;
   localparam int W = 2**N;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   decoder_pipe_if #(.N(N)) bus ();

`ifdef DECODER_PIPE_HITCNT_EN
   logic [N-1:0] cnt_sel = '0;
   logic         cnt_clr = 1'b0;
   logic [7:0]   cnt_out;
   decoder_pipe #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave),
                              .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_out(cnt_out));
`else
   decoder_pipe #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif

   int n_chk  = 0;
   int n_fail = 0;
   logic [W-1:0] sb [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: at each negedge, judge the transfers about to happen at the next rising edge
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         chk("busy_eq_valid", {31'd0, bus.busy}, {31'd0, bus.dout_valid});
         if (!bus.dout_valid) chk("dout_zero_idle", 32'(bus.dout), 32'd0);
         if (bus.dout_valid && bus.dout_ready) begin
            if (sb.size() == 0) chk("sb_unexpected_out", 32'(bus.dout), 32'd0);
            else                chk("sb_dout", 32'(bus.dout), 32'(sb.pop_front()));
         end
         if (bus.din_valid && bus.din_ready) sb.push_back(W'(1) << bus.din);
      end
   end

   task automatic step(input logic [N-1:0] d, input logic v, input logic r);
      @(posedge clk); #1;
      bus.din = d; bus.din_valid = v; bus.dout_ready = r;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; bus.din_valid = 1'b0; bus.dout_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((sb.size() != 0 || bus.dout_valid) && k < 20) begin
         step('0, 1'b0, 1'b1);
         k++;
      end
      chk("drain_timeout", 32'(k < 20), 32'd1);
   endtask

   typedef struct {
      logic [N-1:0] din;
      logic         v;
      logic         r;
      logic [W-1:0] e_dout;
      logic         e_dv;
      logic         e_rdy;
   } vec_t;

   vec_t vt [11];

   initial begin
      bus.din = '0; bus.din_valid = 1'b0; bus.dout_ready = 1'b0;

      // single decode, then back-pressure with 0,7,2 and release
      vt[0]  = '{3'd5, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1};
      vt[1]  = '{3'd0, 1'b0, 1'b1, 8'h20, 1'b1, 1'b1};
      vt[2]  = '{3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
      vt[3]  = '{3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
      vt[4]  = '{3'd7, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1};
      vt[5]  = '{3'd2, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
      vt[6]  = '{3'd2, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
      vt[7]  = '{3'd2, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
      vt[8]  = '{3'd2, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1};
      vt[9]  = '{3'd0, 1'b0, 1'b1, 8'h04, 1'b1, 1'b1};
      vt[10] = '{3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};

      do_reset();
      chk("rst_din_ready",  32'(bus.din_ready),  32'd1);
      chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
      chk("rst_dout",       32'(bus.dout),       32'd0);
      chk("rst_busy",       32'(bus.busy),       32'd0);

      for (int i = 0; i < 11; i++) begin
         step(vt[i].din, vt[i].v, vt[i].r);
         chk($sformatf("vec%0d_dout", i),       32'(bus.dout),       32'(vt[i].e_dout));
         chk($sformatf("vec%0d_dout_valid", i), 32'(bus.dout_valid), 32'(vt[i].e_dv));
         chk($sformatf("vec%0d_din_ready", i),  32'(bus.din_ready),  32'(vt[i].e_rdy));
      end

      // streaming: 24 codes, one per cycle, no bubbles
      for (int i = 0; i < 24; i++) begin
         step(3'(i % 8), 1'b1, 1'b1);
         chk("stream_din_ready", 32'(bus.din_ready), 32'd1);
         if (i > 0) chk("stream_no_gap", 32'(bus.dout_valid), 32'd1);
      end
      step('0, 1'b0, 1'b1);
      chk("stream_last", 32'(bus.dout), 32'h80);
      drain();

      // reset while full: transfers in the reset cycle are dropped
      step(3'd1, 1'b1, 1'b0);
      step(3'd6, 1'b1, 1'b0);
      step(3'd3, 1'b1, 1'b0);
      chk("full_din_ready", 32'(bus.din_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1; bus.din_valid = 1'b1; bus.dout_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; bus.din_valid = 1'b0;
      chk("midrst_dout_valid", 32'(bus.dout_valid), 32'd0);
      chk("midrst_dout",       32'(bus.dout),       32'd0);
      chk("midrst_din_ready",  32'(bus.din_ready),  32'd1);
      for (int i = 0; i < 4; i++) begin
         step('0, 1'b0, 1'b1);
         chk("midrst_no_stale", 32'(bus.dout_valid), 32'd0);
      end

      // random valid/ready traffic against the scoreboard
      for (int i = 0; i < 300; i++)
         step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      drain();

`ifdef DECODER_PIPE_HITCNT_EN
      do_reset();
      for (int i = 0; i < 300; i++) step(3'd4, 1'b1, 1'b1);
      drain();
      cnt_sel = 3'd4;
      step('0, 1'b0, 1'b1);
      step('0, 1'b0, 1'b1);
      chk("cnt_sat", 32'(cnt_out), 32'd255);
      cnt_sel = 3'd3;
      step('0, 1'b0, 1'b1);
      step('0, 1'b0, 1'b1);
      chk("cnt_other", 32'(cnt_out), 32'd0);
      cnt_sel = 3'd4;
      cnt_clr = 1'b1;
      step('0, 1'b0, 1'b1);
      cnt_clr = 1'b0;
      step('0, 1'b0, 1'b1);
      chk("cnt_clr", 32'(cnt_out), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/decoder_pipe.md
DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 Parameter N, default 3, meaning: code width; output width SHALL be 2**N (8 at default).
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge only.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 din  input  N  binary code to decode.
REQ-005 din_valid  input  1  din carries a code this cycle.
REQ-006 din_ready  output  1  block accepts din this cycle.
REQ-007 dout  output  2**N  one-hot decoded value; bit din set.
REQ-008 dout_valid  output  1  dout holds a decoded code.
REQ-009 dout_ready  input  1  sink accepts dout this cycle.
REQ-010 busy  output  1  high whenever any entry is held.

Function
REQ-011 Input transfer SHALL occur when din_valid and din_ready are both high at a rising edge; output transfer when dout_valid and dout_ready are both high.
REQ-012 Block SHALL hold a 2-entry FIFO of decoded one-hot words; decode SHALL occur at input capture: entry = 1 << din.
REQ-013 FSM states SHALL be EMPTY (0 entries), ONE (1 entry), TWO (2 entries); encoding is implementation choice.
REQ-014 EMPTY: accept -> ONE; no accept -> EMPTY.
REQ-015 ONE: accept without output transfer -> TWO; output transfer without accept -> EMPTY; both or neither -> ONE.
REQ-016 TWO: output transfer -> ONE; otherwise stay TWO; no input accepted in TWO.
REQ-017 din_ready SHALL be high in EMPTY and ONE, low in TWO; registered, not combinationally dependent on dout_ready.
REQ-018 dout_valid SHALL be high in ONE and TWO; dout SHALL show the oldest entry; dout SHALL be all-zero when dout_valid is low.
REQ-019 Latency: code accepted at edge k SHALL appear on dout/dout_valid after edge k when FIFO was EMPTY (1 cycle).
REQ-020 Sustained din_valid and dout_ready high SHALL give one transfer per cycle with no bubbles.
REQ-021 Order SHALL be preserved; no entry lost or duplicated.
REQ-022 While dout_valid high and dout_ready low, dout SHALL remain stable.
REQ-023 din with X/Z bits at capture is illegal; behaviour undefined, no checking required.
REQ-024 busy SHALL equal dout_valid.

Reset
REQ-025 With rst high at a rising edge: state EMPTY, din_ready 1 on the following cycle, dout_valid 0, dout 0, busy 0.
REQ-026 Reset mid-operation SHALL discard all held entries; transfers in the reset cycle SHALL be ignored.
REQ-027 rst SHALL take priority over every other input.

Configuration
REQ-028 Macro DECODER_PIPE_HITCNT_EN: when defined, block SHALL add ports cnt_sel (input N), cnt_out (output 8), cnt_clr (input 1).
REQ-029 With macro: one 8-bit saturating counter per output bit, incremented on each output transfer whose dout has that bit set; saturates at 255.
REQ-030 With macro: cnt_out SHALL be counter[cnt_sel], registered (1-cycle latency); cnt_clr high SHALL zero all counters next edge, clear winning over increment; rst SHALL zero all counters.
REQ-031 Without macro: ports and counters absent; REQ-001..027 behaviour identical.

Verification
REQ-032 Reset then din=3'd5, din_valid=1 one cycle, dout_ready=1 -> next cycle dout=8'b0010_0000, dout_valid=1; following cycle dout_valid=0, dout=0.
REQ-033 dout_ready=0, send codes 0,7,2 back-to-back -> din_ready low after 2nd accept, code 2 held off; release dout_ready -> dout 8'h01, 8'h80, 8'h04 in order.
REQ-034 Continuous din_valid/dout_ready=1, codes 0..7 repeated 3 times -> 24 consecutive output transfers, dout=1<<code each, no gaps.
REQ-035 FIFO in TWO, assert rst one cycle -> dout_valid=0, dout=0, din_ready=1 next cycle; no stale entry emerges afterward.
REQ-036 Macro defined: 300 output transfers of code 4, cnt_sel=4 -> cnt_out=255; cnt_sel=3 -> 0; pulse cnt_clr -> cnt_out=0 after 2 cycles.
